// File: rtl/noise_burst_ctrl_pkg.sv
// Shared definitions for the noise burst controller: FSM encoding, LFSR seed
// and the LFSR next-state function.
package noise_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'h0001;

    // x^16+x^14+x^13+x^11+1, shift-left with the feedback entering bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/noise_burst_ctrl_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous active-high reseed and advance enable.
module noise_burst_ctrl_lfsr
    import noise_burst_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/noise_burst_ctrl.sv
// Two-requester round-robin burst controller streaming LFSR noise samples
// over a valid/ready interface.
module noise_burst_ctrl
    import noise_burst_ctrl_pkg::*;
#(
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [BURST_W-1:0] len0,
    input  logic [BURST_W-1:0] len1,
    input  logic [1:0]         reseed,
    output logic [1:0]         grant,
    output logic               busy,
    output logic [15:0]        smp_data,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic               smp_last,
    output logic [1:0]         done
);

    state_t             state;
    logic [BURST_W-1:0] count;
    logic               last_win;
    logic               reseed_q;
    logic               win;
    logic               xfer;
    logic               lfsr_rst;

    // Round-robin: on a tie the requester that was not served last wins;
    // last_win resets to 1 so requester 0 has priority after reset.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
            win = ~last_win;
        end
    end

    assign xfer     = (state == RUN) && smp_valid && smp_ready;
    assign lfsr_rst = ~rst_n | ((state == LOAD) && reseed_q);
    assign busy     = (state != IDLE);

    noise_burst_ctrl_lfsr u_lfsr (
        .clk (clk),
        .rst (lfsr_rst),
        .en  (xfer),
        .q   (smp_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 2'b00;
            smp_valid <= 1'b0;
            smp_last  <= 1'b0;
            done      <= 2'b00;
            count     <= '0;
            last_win  <= 1'b1;
            reseed_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (|req) begin
                        grant    <= win ? 2'b10 : 2'b01;
                        count    <= win ? len1 : len0;
                        reseed_q <= reseed[win];
                        last_win <= win;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (count == '0) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        smp_valid <= 1'b1;
                        smp_last  <= (count == BURST_W'(1));
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // smp_last is computed one transfer ahead so it is
                    // registered yet still coincides with the final sample
                    if (smp_ready) begin
                        count <= count - BURST_W'(1);
                        if (count == BURST_W'(1)) begin
                            smp_valid <= 1'b0;
                            smp_last  <= 1'b0;
                            done      <= grant;
                            state     <= DONE;
                        end else begin
                            smp_last <= (count == BURST_W'(2));
                        end
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_burst_ctrl.sv
// Directed self-checking bench for noise_burst_ctrl with hand-computed vectors.
module tb_noise_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [7:0]  len0 = 8'd0;
    logic [7:0]  len1 = 8'd0;
    logic [1:0]  reseed = 2'b00;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] smp_data;
    logic        smp_valid;
    logic        smp_ready = 1'b0;
    logic        smp_last;
    logic [1:0]  done;

    int total = 0;
    int bad = 0;

    // Hand-derived noise sequence from seed 0x0001
    logic [15:0] seq [0:11];

    logic        stall_rdy [0:4];
    logic [15:0] stall_dat [0:4];
    logic        stall_lst [0:4];

    always #5 clk = ~clk;

    noise_burst_ctrl #(.BURST_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .reseed    (reseed),
        .grant     (grant),
        .busy      (busy),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_last  (smp_last),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [7:0] l0,
                                 input logic [7:0] l1, input logic [1:0] rs,
                                 input logic rdy);
        req       = r;
        len0      = l0;
        len1      = l1;
        reseed    = rs;
        smp_ready = rdy;
    endtask

    // Walks LOAD, n RUN cycles (ready held high) and DONE, starting at seq[base]
    task automatic checkBurst(input string tag, input logic [1:0] g,
                              input int n, input int base);
        @(negedge clk);
        checkOutput({tag, "_load_grant"}, 16'(grant), 16'(g));
        checkOutput({tag, "_load_busy"}, 16'(busy), 16'd1);
        checkOutput({tag, "_load_valid"}, 16'(smp_valid), 16'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput({tag, "_data"}, smp_data, seq[base + i]);
            checkOutput({tag, "_valid"}, 16'(smp_valid), 16'd1);
            checkOutput({tag, "_last"}, 16'(smp_last), 16'(i == n - 1));
        end
        @(negedge clk);
        checkOutput({tag, "_done"}, 16'(done), 16'(g));
        checkOutput({tag, "_done_valid"}, 16'(smp_valid), 16'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        seq = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020,
                16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801};
        stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        stall_dat = '{16'h0001, 16'h0002, 16'h0002, 16'h0002, 16'h0004};
        stall_lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_grant", 16'(grant), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_valid", 16'(smp_valid), 16'd0);
        checkOutput("rst_last", 16'(smp_last), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_data", smp_data, 16'h0001);

        // Single reseeded burst of 4
        rst_n = 1'b1;
        applyStimulus(2'b01, 8'd4, 8'd0, 2'b01, 1'b1);
        checkBurst("basic", 2'b01, 4, 0);
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("basic_idle_busy", 16'(busy), 16'd0);
        checkOutput("basic_idle_grant", 16'(grant), 16'd0);
        checkOutput("basic_idle_done", 16'(done), 16'd0);

        // Simultaneous requests after reset: 0 first, then 1 continuing the sequence
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b11, 8'd2, 8'd2, 2'b00, 1'b1);
        checkBurst("rr_first", 2'b01, 2, 0);
        applyStimulus(2'b10, 8'd2, 8'd2, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("rr_gap_busy", 16'(busy), 16'd0);
        checkBurst("rr_second", 2'b10, 2, 2);
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);

        // Zero-length burst: LOAD straight to DONE with no samples
        applyStimulus(2'b10, 8'd0, 8'd0, 2'b00, 1'b1);
        checkBurst("zero_len", 2'b10, 0, 0);
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("zero_idle_valid", 16'(smp_valid), 16'd0);

        // Reseeded burst of 12 ending at 0x0801
        applyStimulus(2'b01, 8'd12, 8'd0, 2'b01, 1'b1);
        checkBurst("len12", 2'b01, 12, 0);
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);

        // Backpressure: ready 1,0,0,1,1 over a 3-sample burst
        applyStimulus(2'b01, 8'd3, 8'd0, 2'b01, 1'b1);
        @(negedge clk);
        checkOutput("stall_load_grant", 16'(grant), 16'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_data", smp_data, stall_dat[i]);
            checkOutput("stall_valid", 16'(smp_valid), 16'd1);
            checkOutput("stall_last", 16'(smp_last), 16'(stall_lst[i]));
            smp_ready = stall_rdy[i];
        end
        @(negedge clk);
        checkOutput("stall_done", 16'(done), 16'b01);
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);

        // Reset mid-burst aborts without done; next burst restarts at seed
        applyStimulus(2'b01, 8'd5, 8'd0, 2'b01, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("abort_pre_data", smp_data, 16'h0002);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_grant", 16'(grant), 16'd0);
        checkOutput("abort_busy", 16'(busy), 16'd0);
        checkOutput("abort_valid", 16'(smp_valid), 16'd0);
        checkOutput("abort_last", 16'(smp_last), 16'd0);
        checkOutput("abort_done", 16'(done), 16'd0);
        rst_n = 1'b1;
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("abort_after_done", 16'(done), 16'd0);
        checkOutput("abort_after_busy", 16'(busy), 16'd0);
        applyStimulus(2'b01, 8'd2, 8'd0, 2'b00, 1'b1);
        checkBurst("resume", 2'b01, 2, 0);
        applyStimulus(2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noise_burst_ctrl.md
NOISE_BURST_CTRL -- requirements
Module: noise_burst_ctrl

Interface
REQ-001 Parameter BURST_W, default 8: width of burst-length inputs and internal sample counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req  input  2  per-requester burst request; level, held until matching done pulse.
REQ-005 len0, len1  input  BURST_W each  burst length in samples for requester 0/1, sampled at grant.
REQ-006 reseed  input  2  per-requester flag, sampled at grant: restart the noise sequence at seed 0x0001.
REQ-007 grant  output  2  one-hot; the requester owning the current burst.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 smp_data  output  16  current pseudo-random sample.
REQ-010 smp_valid  output  1  sample-valid strobe.
REQ-011 smp_ready  input  1  downstream accept.
REQ-012 smp_last  output  1  high with the final sample of a burst.
REQ-013 done  output  2  one-cycle pulse per requester when its burst completes.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: if req nonzero, the arbiter selects a winner, latches its length and reseed bit, asserts grant next cycle, and goes to LOAD; otherwise stays in IDLE.
REQ-016 Arbitration: round-robin; a requester that was not served last wins a tie; after reset requester 0 has priority.
REQ-017 LOAD (1 cycle): if the latched reseed is 1, assert the LFSR reset so the first sample is 0x0001; otherwise the sequence continues from its retained state. Latched length 0 goes directly to DONE with no samples emitted; otherwise go to RUN.
REQ-018 RUN: smp_valid=1 and smp_data=LFSR output; the LFSR advances only on the cycle where smp_valid and smp_ready are both 1; the counter decrements on the same cycle.
REQ-019 smp_data and smp_valid hold steady while smp_ready=0 (no sample is dropped or skipped).
REQ-020 smp_last=1 exactly while in RUN with the remaining count equal to 1.
REQ-021 The transfer of the last sample moves the FSM to DONE; smp_valid is 0 in the following cycle.
REQ-022 DONE (1 cycle): done bit of the granted requester=1, grant cleared at the exit; return to IDLE.
REQ-023 Deassertion of req during LOAD/RUN is ignored; the burst completes.
REQ-024 New requests are evaluated only in IDLE; the minimum gap between bursts is one IDLE cycle.
REQ-025 LFSR: 16-bit, polynomial x^16+x^14+x^13+x^11+1, shift-left with feedback bit15^bit13^bit12^bit10 into bit0, seed 0x0001.
REQ-026 Counter is BURST_W bits, unsigned; maximum burst length is 2^BURST_W-1; no wrap-around within a burst.

Reset
REQ-027 rst_n=0 at a clock edge forces IDLE, grant=0, busy=0, smp_valid=0, smp_last=0, done=0, counter=0, arbiter priority to requester 0, LFSR=0x0001.
REQ-028 Reset mid-burst aborts the burst with no done pulse; the output values of REQ-027 are visible in the cycle after the reset edge.

Structure
REQ-029 The one sub-module is the existing lfsr instance. The controller drives its en with the transfer condition and its active-high rst with (not rst_n) OR (LOAD and latched reseed).
REQ-030 The state encoding and the seed constant 0x0001 are defined in a shared package; no other typedefs are required.

Verification
REQ-031 Reset, then req=01, len0=4, reseed=01, smp_ready=1 -> samples 0x0001, 0x0002, 0x0004, 0x0008; smp_last on the 4th; done=01 one cycle later.
REQ-032 req=11 simultaneously after reset, lengths 2 and 2 -> requester 0 served first, then requester 1; the second burst continues with 0x0004, 0x0008 (reseed=0).
REQ-033 Reseed burst of length 12 with ready=1 -> the 12th sample is 0x0801.
REQ-034 Toggle smp_ready 1,0,0,1 during RUN -> smp_data holds across the stall; the LFSR advances only on accepted cycles.
REQ-035 len1=0 with req=10 -> LOAD, DONE, done=10, and no smp_valid.
REQ-036 rst_n=0 mid-burst -> next cycle all outputs 0 and no done pulse; the next reseed-less burst starts at 0x0001.
